// File: rtl/shift_sequencer_if.sv
// Control/handshake bundle between the shift sequencer and its upstream, datapath and
// downstream users.
interface shift_sequencer_if #(
  parameter int unsigned NBITS = 16
);
  localparam int unsigned CNT_W = (NBITS > 1) ? $clog2(NBITS) : 1;

  logic             start;
  logic             ready;
  logic             abort;
  logic             load;
  logic             shift_en;
  logic [CNT_W-1:0] bit_idx;
  logic             last;
  logic             done;
  logic             ack;
  logic             busy;

  modport master (
    input  start, abort, ack,
    output ready, load, shift_en, bit_idx, last, done, busy
  );

  modport slave (
    output start, abort, ack,
    input  ready, load, shift_en, bit_idx, last, done, busy
  );
endinterface

// File: rtl/shift_sequencer.sv
// Sequences a serial shift datapath: one load strobe, exactly NBITS shift-enable cycles,
// then a result-valid held until acknowledged. Outputs decode only registered state.
module shift_sequencer #(
  parameter int unsigned NBITS = 16
) (
  input logic              i_clk,
  input logic              i_rst,
  shift_sequencer_if.master ctrl
);
  localparam int unsigned CNT_W = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam logic [CNT_W-1:0] LastIdx = CNT_W'(NBITS - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

  state_e           r_state;
  state_e           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Abort wins over every forward transition; the counter is zero outside SHIFT.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = '0;
    unique case (r_state)
      StIdle: begin
        if (ctrl.start && !ctrl.abort) w_state_next = StLoad;
      end
      StLoad: begin
        w_state_next = ctrl.abort ? StIdle : StShift;
      end
      StShift: begin
        if (ctrl.abort) begin
          w_state_next = StIdle;
        end else if (r_cnt == LastIdx) begin
          w_state_next = StDone;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      StDone: begin
        if (ctrl.abort || ctrl.ack) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  logic w_in_shift;
  assign w_in_shift = (r_state == StShift);

  assign ctrl.ready    = (r_state == StIdle);
  assign ctrl.busy     = (r_state != StIdle);
  assign ctrl.load     = (r_state == StLoad);
  assign ctrl.shift_en = w_in_shift;
  assign ctrl.bit_idx  = w_in_shift ? r_cnt : '0;
  assign ctrl.last     = w_in_shift && (r_cnt == LastIdx);
  assign ctrl.done     = (r_state == StDone);
endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: an NBITS=8 instance for the main scenarios and an
// NBITS=1 instance for the single-shift edge case.
module tb_shift_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  shift_sequencer_if #(.NBITS(8)) ifc8 ();
  shift_sequencer_if #(.NBITS(1)) ifc1 ();

  shift_sequencer #(.NBITS(8)) u_dut8 (.i_clk(clk), .i_rst(rst), .ctrl(ifc8.master));
  shift_sequencer #(.NBITS(1)) u_dut1 (.i_clk(clk), .i_rst(rst), .ctrl(ifc1.master));

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int n_load = 0;
  int n_shift = 0;
  int n_done = 0;
  int load_cyc[$];
  logic mon_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (mon_en) begin
      if (ifc8.load) begin
        n_load++;
        load_cyc.push_back(cyc);
      end
      if (ifc8.shift_en) n_shift++;
      if (ifc8.done) n_done++;
      check("excl8", 32'($countones({ifc8.load, ifc8.shift_en, ifc8.done}) <= 1), 32'd1);
      check("rdybusy8", 32'(ifc8.ready ^ ifc8.busy), 32'd1);
      check("rdybusy1", 32'(ifc1.ready ^ ifc1.busy), 32'd1);
    end
  end

  task automatic check_idle8(input string tag);
    check({tag, "_ready"}, 32'(ifc8.ready), 32'd1);
    check({tag, "_busy"}, 32'(ifc8.busy), 32'd0);
    check({tag, "_load"}, 32'(ifc8.load), 32'd0);
    check({tag, "_shift"}, 32'(ifc8.shift_en), 32'd0);
    check({tag, "_done"}, 32'(ifc8.done), 32'd0);
    check({tag, "_last"}, 32'(ifc8.last), 32'd0);
    check({tag, "_idx"}, 32'(ifc8.bit_idx), 32'd0);
  endtask

  initial begin
    ifc8.start = 1'b0; ifc8.abort = 1'b0; ifc8.ack = 1'b0;
    ifc1.start = 1'b0; ifc1.abort = 1'b0; ifc1.ack = 1'b0;

    // Reset then idle
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    mon_en = 1'b1;
    check_idle8("rst");
    check("rst1_ready", 32'(ifc1.ready), 32'd1);
    ifc8.ack = 1'b1; ifc8.abort = 1'b1;
    tick();
    ifc8.ack = 1'b0; ifc8.abort = 1'b0;
    tick();
    check_idle8("idle_ackabort");

    // Nominal operation
    n_load = 0; n_shift = 0;
    ifc8.start = 1'b1;
    tick();
    ifc8.start = 1'b0;
    check("nom_load", 32'(ifc8.load), 32'd1);
    check("nom_busy", 32'(ifc8.busy), 32'd1);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("nom_shift", 32'(ifc8.shift_en), 32'd1);
      check("nom_idx", 32'(ifc8.bit_idx), 32'(i));
      check("nom_last", 32'(ifc8.last), (i == 7) ? 32'd1 : 32'd0);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      check("nom_done", 32'(ifc8.done), 32'd1);
    end
    ifc8.ack = 1'b1;
    tick();
    ifc8.ack = 1'b0;
    check_idle8("nom_end");
    check("nom_nload", 32'(n_load), 32'd1);
    check("nom_nshift", 32'(n_shift), 32'd8);

    // Back-to-back with start and ack held high
    load_cyc.delete();
    n_load = 0; n_shift = 0;
    ifc8.start = 1'b1; ifc8.ack = 1'b1;
    for (int i = 0; i < 36; i++) tick();
    ifc8.start = 1'b0;
    for (int k = 0; k < 30 && !ifc8.ready; k++) tick();
    check("b2b_drain", 32'(ifc8.ready), 32'd1);
    ifc8.ack = 1'b0;
    check("b2b_nload", 32'(load_cyc.size()), 32'd4);
    for (int i = 1; i < load_cyc.size(); i++)
      check("b2b_period", 32'(load_cyc[i] - load_cyc[i-1]), 32'd11);
    check("b2b_nshift", 32'(n_shift), 32'd32);

    // Abort mid-shift
    n_done = 0;
    ifc8.start = 1'b1;
    tick();
    ifc8.start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("abt_idx4", 32'(ifc8.bit_idx), 32'd4);
    ifc8.abort = 1'b1;
    tick();
    ifc8.abort = 1'b0;
    check_idle8("abt");
    for (int i = 0; i < 12; i++) tick();
    check("abt_nodone", 32'(n_done), 32'd0);
    n_shift = 0;
    ifc8.start = 1'b1;
    tick();
    ifc8.start = 1'b0; ifc8.ack = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    ifc8.ack = 1'b0;
    check("abt_refresh_ready", 32'(ifc8.ready), 32'd1);
    check("abt_refresh_nshift", 32'(n_shift), 32'd8);

    // Simultaneous events
    ifc8.start = 1'b1; ifc8.abort = 1'b1;
    tick();
    ifc8.start = 1'b0; ifc8.abort = 1'b0;
    check_idle8("startabort");
    ifc8.start = 1'b1;
    tick();
    ifc8.start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    check("abtack_done", 32'(ifc8.done), 32'd1);
    ifc8.abort = 1'b1; ifc8.ack = 1'b1;
    tick();
    ifc8.abort = 1'b0; ifc8.ack = 1'b0;
    check_idle8("abtack");
    ifc8.start = 1'b1;
    tick();
    ifc8.start = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("rst_idx5", 32'(ifc8.bit_idx), 32'd5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle8("midrst");

    // NBITS=1 edge case
    ifc1.start = 1'b1;
    tick();
    ifc1.start = 1'b0;
    check("n1_load", 32'(ifc1.load), 32'd1);
    tick();
    check("n1_shift", 32'(ifc1.shift_en), 32'd1);
    check("n1_last", 32'(ifc1.last), 32'd1);
    check("n1_idx", 32'(ifc1.bit_idx), 32'd0);
    tick();
    check("n1_done", 32'(ifc1.done), 32'd1);
    check("n1_shiftoff", 32'(ifc1.shift_en), 32'd0);
    ifc1.ack = 1'b1;
    tick();
    ifc1.ack = 1'b0;
    check("n1_ready", 32'(ifc1.ready), 32'd1);
    check("n1_idx_end", 32'(ifc1.bit_idx), 32'd0);

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
